// File: rtl/accel_chan_mux.sv
// Packet-level round-robin arbiter that tags beats into one accelerator stream, plus an ID-steered return demux.
// Optional per-channel forward packet counters are enabled by defining ACCEL_MUX_PKT_CNT_EN.
module accel_chan_mux #(
  parameter int N_CHAN = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_CHAN*DATA_W-1:0] s_tdata,
  input  logic [N_CHAN-1:0]        s_tvalid,
  input  logic [N_CHAN-1:0]        s_tlast,
  output logic [N_CHAN-1:0]        s_tready,
  output logic [DATA_W-1:0]        acc_o_tdata,
  output logic                     acc_o_tvalid,
  output logic                     acc_o_tlast,
  output logic [ID_W-1:0]          acc_o_tid,
  input  logic                     acc_o_tready,
  input  logic [DATA_W-1:0]        acc_i_tdata,
  input  logic                     acc_i_tvalid,
  input  logic                     acc_i_tlast,
  input  logic [ID_W-1:0]          acc_i_tid,
  output logic                     acc_i_tready,
  output logic [N_CHAN*DATA_W-1:0] m_tdata,
  output logic [N_CHAN-1:0]        m_tvalid,
  output logic [N_CHAN-1:0]        m_tlast,
  input  logic [N_CHAN-1:0]        m_tready,
  input  logic [N_CHAN-1:0]        chan_en,
  output logic                     busy,
  output logic                     err_bad_id,
  output logic [N_CHAN*CNT_W-1:0]  pkt_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;
  localparam int ENT_W = DATA_W + 1 + ID_W;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   grant_reg, grant_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_found;
  logic [N_CHAN-1:0] req;
  logic [ENT_W-1:0]  head_reg, tail_reg, push_ent;
  logic [1:0]        count_reg;
  logic              push, pop, full;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid, sel_last;
  logic              tid_ok;
  logic [N_CHAN-1:0] ready_hit;
  logic              err_bad_id_reg;

  assign req  = s_tvalid & chan_en;
  assign full = (count_reg == 2'd2);

  // First requester found scanning cyclically upward from rr_ptr+1.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int k = 1; k <= N_CHAN; k++) begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (!arb_found && req[i] && (i == ((int'(rr_ptr_reg) + k) % N_CHAN))) begin
          arb_idx   = ID_W'(i);
          arb_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (grant_reg == ID_W'(i)) begin
        sel_data  = s_tdata[i*DATA_W +: DATA_W];
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
      end
    end
  end

  assign push     = (state_reg == GRANT) && sel_valid && !full;
  assign pop      = acc_o_tvalid && acc_o_tready;
  assign push_ent = {sel_data, sel_last, grant_reg};

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (arb_found) begin
          grant_next = arb_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (push && sel_last) begin
          rr_ptr_next = grant_reg;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= ID_W'(N_CHAN - 1);
      count_reg      <= 2'd0;
      err_bad_id_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      rr_ptr_reg     <= rr_ptr_next;
      err_bad_id_reg <= acc_i_tvalid && !tid_ok;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head always drives acc_o_*; push with pop at count 1 refills head directly.
  always_ff @(posedge aclk) begin
    if (pop) begin
      head_reg <= (count_reg == 2'd2) ? tail_reg : push_ent;
    end else if (push) begin
      if (count_reg == 2'd0) head_reg <= push_ent;
      else                   tail_reg <= push_ent;
    end
  end

  assign acc_o_tvalid = (count_reg != 2'd0);
  assign {acc_o_tdata, acc_o_tlast, acc_o_tid} = head_reg;
  assign busy       = (state_reg == GRANT) || (count_reg != 2'd0);
  assign err_bad_id = err_bad_id_reg;

  assign tid_ok       = ({1'b0, acc_i_tid} < (ID_W + 1)'(N_CHAN));
  assign acc_i_tready = tid_ok ? (|ready_hit) : 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
      assign s_tready[gi] = (state_reg == GRANT) && (grant_reg == ID_W'(gi)) && !full;
      assign m_tvalid[gi]  = acc_i_tvalid && (acc_i_tid == ID_W'(gi));
      assign ready_hit[gi] = m_tready[gi] && (acc_i_tid == ID_W'(gi));
      assign m_tdata[gi*DATA_W +: DATA_W] = acc_i_tdata;
      assign m_tlast[gi] = acc_i_tlast;
    end
  endgenerate

`ifdef ACCEL_MUX_PKT_CNT_EN
  generate
    for (gi = 0; gi < N_CHAN; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge aclk) begin
        if (!aresetn)
          cnt_reg <= '0;
        else if (s_tvalid[gi] && s_tready[gi] && s_tlast[gi])
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
      assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_accel_chan_mux.sv
// Bench for accel_chan_mux: queue-based reference model checked every cycle, directed scenarios, then random traffic.
module tb_accel_chan_mux;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int CW = 16;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]   acc_o_tdata;
  logic            acc_o_tvalid, acc_o_tlast, acc_o_tready;
  logic [IW-1:0]   acc_o_tid;
  logic [DW-1:0]   acc_i_tdata;
  logic            acc_i_tvalid, acc_i_tlast, acc_i_tready;
  logic [IW-1:0]   acc_i_tid;
  logic [N*DW-1:0] m_tdata;
  logic [N-1:0]    m_tvalid, m_tlast, m_tready, chan_en;
  logic            busy, err_bad_id;
  logic [N*CW-1:0] pkt_cnt;

  always #5 aclk = ~aclk;

  accel_chan_mux #(.N_CHAN(N), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .acc_o_tdata(acc_o_tdata), .acc_o_tvalid(acc_o_tvalid), .acc_o_tlast(acc_o_tlast),
    .acc_o_tid(acc_o_tid), .acc_o_tready(acc_o_tready),
    .acc_i_tdata(acc_i_tdata), .acc_i_tvalid(acc_i_tvalid), .acc_i_tlast(acc_i_tlast),
    .acc_i_tid(acc_i_tid), .acc_i_tready(acc_i_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .chan_en(chan_en), .busy(busy), .err_bad_id(err_bad_id), .pkt_cnt(pkt_cnt)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  tid;
    logic        last;
    logic [31:0] data;
  } beat_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sv_cyc = -1;
  int stall_hs = 0;
  int err_pulses = 0;
  bit checking = 0;
  bit gaps = 0, stall = 0, rnd_rdy = 0, ret_rnd = 0;
  logic [N-1:0] hs = '0;
  logic [DW:0] src_q [N][$];
  beat_t out_log[$];

  // Reference model state: packet in progress, granted channel, last winner, output buffer as a queue.
  bit          m_grant = 0;
  int          m_g = 0;
  int          m_rr = N - 1;
  logic [36:0] m_q[$];
  bit          m_err = 0;
  logic [15:0] m_cnt [N];

  logic [N-1:0] exp_rdy, exp_mv, req;
  logic         exp_ir, do_pop, do_push, was_grant, found;
  logic [63:0]  exp_cnt;
  beat_t        bt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge aclk) begin
    cyc++;
    if (checking) begin
      exp_rdy = '0;
      if (m_grant && m_q.size() < 2) exp_rdy[m_g] = 1'b1;
      chk("s_tready", s_tready, exp_rdy);
      chk("acc_o_tvalid", acc_o_tvalid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        chk("acc_o_tdata", acc_o_tdata, m_q[0][36:5]);
        chk("acc_o_tlast", acc_o_tlast, m_q[0][4]);
        chk("acc_o_tid", acc_o_tid, m_q[0][3:0]);
      end
      chk("busy", busy, m_grant || m_q.size() > 0);
      exp_mv = '0;
      exp_ir = 1'b1;
      if (acc_i_tid < 4) begin
        exp_mv[acc_i_tid] = acc_i_tvalid;
        exp_ir = m_tready[acc_i_tid];
      end
      chk("m_tvalid", m_tvalid, exp_mv);
      chk("acc_i_tready", acc_i_tready, exp_ir);
      if (acc_i_tvalid) begin
        for (int i = 0; i < N; i++) begin
          chk("m_tdata", m_tdata[i*DW +: DW], acc_i_tdata);
          chk("m_tlast", m_tlast[i], acc_i_tlast);
        end
      end
      chk("err_bad_id", err_bad_id, m_err);
`ifdef ACCEL_MUX_PKT_CNT_EN
      exp_cnt = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
`else
      exp_cnt = '0;
`endif
      chk("pkt_cnt", pkt_cnt, exp_cnt);
    end

    if (acc_o_tvalid && acc_o_tready) begin
      bt.cyc = cyc; bt.tid = acc_o_tid; bt.last = acc_o_tlast; bt.data = acc_o_tdata;
      out_log.push_back(bt);
    end
    if (sv_cyc < 0 && s_tvalid != 0) sv_cyc = cyc;
    if (err_bad_id) err_pulses++;
    hs = s_tvalid & s_tready;
    if (stall) stall_hs += $countones(hs);

    // Advance the model to the state after the coming rising edge.
    if (!aresetn) begin
      m_grant = 0; m_rr = N - 1; m_q.delete(); m_err = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
      checking = 1;
    end else begin
      was_grant = m_grant;
      do_pop  = (m_q.size() > 0) && acc_o_tready;
      do_push = m_grant && (m_q.size() < 2) && s_tvalid[m_g];
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back({s_tdata[m_g*DW +: DW], s_tlast[m_g], 4'(m_g)});
        if (s_tlast[m_g]) begin
          m_rr = m_g; m_grant = 0; m_cnt[m_g] = m_cnt[m_g] + 16'd1;
        end
      end
      if (!was_grant) begin
        req = s_tvalid & chan_en;
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req[(m_rr + k) % N]) begin
            m_g = (m_rr + k) % N; m_grant = 1; found = 1;
          end
        end
      end
      m_err = acc_i_tvalid && (acc_i_tid >= 4);
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i] = gaps ? ($urandom_range(3) != 0) : 1'b1;
        s_tdata[i*DW +: DW] = src_q[i][0][DW-1:0];
        s_tlast[i] = src_q[i][0][DW];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i*DW +: DW] = $urandom;
        s_tlast[i] = 1'($urandom_range(1));
      end
    end
    acc_o_tready = stall ? 1'b0 : (rnd_rdy ? ($urandom_range(3) != 0) : 1'b1);
    if (ret_rnd) begin
      acc_i_tvalid = 1'($urandom_range(1));
      acc_i_tid    = ($urandom_range(5) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
      acc_i_tdata  = $urandom;
      acc_i_tlast  = 1'($urandom_range(1));
      m_tready     = 4'($urandom);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic add_pkt(input int ch, input int len, input logic [31:0] base);
    for (int b = 0; b < len; b++) src_q[ch].push_back({b == len - 1, base + 32'(b)});
  endtask

  task automatic wait_out(input int n, input int budget);
    int t = 0;
    while (out_log.size() < n && t < budget) begin step(); t++; end
    if (out_log.size() < n) chk("wait_out_timeout", 64'(out_log.size()), 64'(n));
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive();
    step();
    step();
    aresetn = 1'b1;
    out_log.delete();
    sv_cyc = -1; stall_hs = 0; err_pulses = 0;
    chk("reset_busy", busy, 0);
    chk("reset_tvalid", acc_o_tvalid, 0);
    chk("reset_s_tready", s_tready, 0);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int pre, n2;

  initial begin
    aresetn = 1'b0; s_tvalid = '0; s_tdata = '0; s_tlast = '0; acc_o_tready = 1'b1;
    acc_i_tdata = '0; acc_i_tvalid = 1'b0; acc_i_tlast = 1'b0; acc_i_tid = '0;
    m_tready = '0; chan_en = '1;

    // Single 3-beat packet on channel 2.
    do_reset();
    add_pkt(2, 3, 32'h2000);
    drive();
    wait_out(3, 20);
    chk("t1_latency", 64'(out_log[0].cyc - sv_cyc), 2);
    for (int b = 0; b < 3; b++) begin
      $display("t1 beat %0d tid=%0d last=%0b data=%h", b, out_log[b].tid, out_log[b].last, out_log[b].data);
      chk("t1_tid", out_log[b].tid, 2);
      chk("t1_last", out_log[b].last, b == 2);
      chk("t1_data", out_log[b].data, 32'h2000 + 32'(b));
    end
    step(); step();
    chk("t1_idle", busy, 0);

    // Round-robin order with all channels requesting.
    do_reset();
    add_pkt(0, 1, 32'h10); add_pkt(0, 1, 32'h11);
    add_pkt(1, 1, 32'h20); add_pkt(2, 1, 32'h30); add_pkt(3, 1, 32'h40);
    drive();
    wait_out(5, 40);
    for (int b = 0; b < 5; b++) begin
      $display("t2 grant %0d tid=%0d", b, out_log[b].tid);
      chk("t2_order", out_log[b].tid, 4'(exp_order[b]));
    end
`ifdef ACCEL_MUX_PKT_CNT_EN
    chk("t2_pkt_cnt", pkt_cnt, {16'd1, 16'd1, 16'd1, 16'd2});
`else
    chk("t2_pkt_cnt", pkt_cnt, 0);
`endif

    // Channel 2 disabled.
    do_reset();
    chan_en = 4'b1011;
    for (int i = 0; i < N; i++) begin add_pkt(i, 1, 32'(i * 16)); add_pkt(i, 1, 32'(i * 16 + 1)); end
    drive();
    wait_out(6, 60);
    repeat (10) step();
    n2 = 0;
    foreach (out_log[b]) if (out_log[b].tid == 2) n2++;
    $display("t3 beats=%0d ch2_beats=%0d", out_log.size(), n2);
    chk("t3_ch2_never", 64'(n2), 0);
    chk("t3_count", 64'(out_log.size()), 6);
    chan_en = '1;

    // chan_en[0] dropped mid-packet.
    do_reset();
    add_pkt(0, 4, 32'h300);
    drive();
    wait_out(1, 20);
    chan_en[0] = 1'b0;
    wait_out(4, 20);
    for (int b = 0; b < 4; b++) begin
      $display("t3b beat %0d tid=%0d last=%0b", b, out_log[b].tid, out_log[b].last);
      chk("t3b_tid", out_log[b].tid, 0);
      chk("t3b_last", out_log[b].last, b == 3);
    end
    chan_en = '1;

    // Back-pressure for 5 cycles mid-burst.
    do_reset();
    add_pkt(1, 8, 32'h100);
    drive();
    wait_out(2, 20);
    pre = out_log.size();
    stall = 1; stall_hs = 0;
    drive();
    repeat (5) step();
    $display("t4 stall accepted=%0d delivered=%0d", stall_hs, out_log.size());
    chk("t4_ready_low", s_tready[1], 0);
    chk("t4_stall_accepts", stall_hs <= 2, 1);
    chk("t4_hold", 64'(out_log.size()), 64'(pre));
    stall = 0;
    drive();
    wait_out(8, 30);
    for (int b = 0; b < 8; b++) begin
      chk("t4_data", out_log[b].data, 32'h100 + 32'(b));
      if (b > pre) chk("t4_rate", 64'(out_log[b].cyc - out_log[b-1].cyc), 1);
    end

    // Return path: valid ID then out-of-range ID.
    do_reset();
    acc_i_tvalid = 1'b1; acc_i_tid = 4'd1; acc_i_tdata = 32'hABCD; acc_i_tlast = 1'b1; m_tready = 4'b0010;
    #1;
    $display("t5 tid=1 m_tvalid=%b acc_i_tready=%0b", m_tvalid, acc_i_tready);
    chk("t5_mvalid1", m_tvalid, 4'b0010);
    chk("t5_ready1", acc_i_tready, 1);
    chk("t5_data1", m_tdata[1*DW +: DW], 32'hABCD);
    step();
    acc_i_tid = 4'd7; m_tready = 4'b0000;
    #1;
    $display("t5 tid=7 m_tvalid=%b acc_i_tready=%0b", m_tvalid, acc_i_tready);
    chk("t5_mvalid7", m_tvalid, 0);
    chk("t5_ready7", acc_i_tready, 1);
    chk("t5_err_pre", err_bad_id, 0);
    step();
    acc_i_tvalid = 1'b0;
    #1;
    chk("t5_err_pulse", err_bad_id, 1);
    step();
    chk("t5_err_clear", err_bad_id, 0);
    chk("t5_err_count", 64'(err_pulses), 1);

    // Reset in the middle of a channel-3 packet.
    do_reset();
    add_pkt(3, 6, 32'h3000);
    drive();
    wait_out(2, 20);
    aresetn = 1'b0;
    step();
    $display("t6 after reset valid=%0b busy=%0b", acc_o_tvalid, busy);
    chk("t6_tvalid", acc_o_tvalid, 0);
    chk("t6_busy", busy, 0);
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    out_log.delete();
    add_pkt(3, 1, 32'h33); add_pkt(0, 1, 32'h44);
    drive();
    wait_out(2, 20);
    $display("t6 first grants %0d,%0d", out_log[0].tid, out_log[1].tid);
    chk("t6_first", out_log[0].tid, 0);
    chk("t6_second", out_log[1].tid, 3);

    // Random traffic on both paths.
    do_reset();
    gaps = 1; rnd_rdy = 1; ret_rnd = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        int ch;
        ch = int'($urandom_range(3));
        if (src_q[ch].size() < 10) add_pkt(ch, int'($urandom_range(5, 1)), $urandom);
      end
      if ($urandom_range(63) == 0) chan_en = 4'($urandom);
      aresetn = (c % 997 != 996);
      step();
    end
    aresetn = 1'b1;
    gaps = 0; rnd_rdy = 0; ret_rnd = 0; chan_en = '1;
    acc_i_tvalid = 1'b0;
    repeat (200) step();
    chk("drain_busy", busy, 0);
    chk("drain_src", 64'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 0);
    $display("random phase delivered %0d beats, bad-id pulses %0d", out_log.size(), err_pulses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

endmodule
